exc_irq_ctrl: RTL
=================

EXC_IRQ_CTRL -- requirements
Module: exc_irq_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 4, range 1..8: number of external interrupt channels.
REQ-002 Parameter PC_W, default 64: width of the captured return address.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 Reset  input  1  reset, synchronous, active-high.
REQ-005 ExtIRQ  input  NUM_IRQ  level interrupt lines, one per channel.
REQ-006 IrqMask  input  NUM_IRQ  1 = channel masked (edge still latched, not taken).
REQ-007 NotAnInstr  input  1  decoder flag: current opcode is invalid.
REQ-008 ERet  input  1  decoder flag: ERET is executing.
REQ-009 ExcAck  input  1  one-cycle pulse: pipeline has redirected to the handler.
REQ-010 Pc  input  PC_W  PC of the instruction in decode.
REQ-011 Exc  output  1  exception request to the pipeline.
REQ-012 EStatus  output  4  exception cause.
REQ-013 ExtIAck  output  NUM_IRQ  one-cycle per-channel interrupt acknowledge.
REQ-014 Elr  output  PC_W  return address captured at acknowledge.
REQ-015 InHandler  output  1  handler active; nesting is disabled.
REQ-016 DoubleFault  output  1  sticky flag: invalid opcode seen while in handler.

Function
REQ-017 Cause encoding: 0000 none, 0001 IRQ channel 0, 0010 invalid opcode, 1kkk IRQ channel k (k=1..7).
REQ-018 pending[k] is set one cycle after a 0->1 transition of ExtIRQ[k], detected against a registered copy of ExtIRQ.
REQ-019 pending[k] is cleared in the cycle that ExtIAck[k] is asserted.
REQ-020 A new edge on a channel wins over that channel's clear in the same cycle.
REQ-021 Eligible set = pending & ~IrqMask; the lowest-index eligible channel has highest priority.
REQ-022 FSM states: IDLE, REQ, HANDLER.
REQ-023 IDLE -> REQ when NotAnInstr=1; EStatus <= 0010; NotAnInstr has priority over any eligible IRQ.
REQ-024 IDLE -> REQ when NotAnInstr=0 and the eligible set is non-zero; EStatus <= code of the winning channel; chosen channel index is latched.
REQ-025 Exc = 1 exactly while in REQ (registered, no combinational path from inputs).
REQ-026 In REQ, the cause and channel stay frozen; later edges only update pending.
REQ-027 REQ -> HANDLER on ExcAck=1: Elr <= Pc in that cycle; for an IRQ cause, ExtIAck[ch]=1 for exactly that one cycle (asserted when ExcAck and the interrupt cause coincide).
REQ-028 HANDLER: InHandler=1, Exc=0; pending keeps accumulating; no new exception is taken.
REQ-029 HANDLER -> IDLE on ERet=1; EStatus <= 0000; Elr holds its value.
REQ-030 NotAnInstr=1 in HANDLER sets DoubleFault; state is unchanged.
REQ-031 ERet in IDLE or REQ is ignored; ExcAck outside REQ is ignored.
REQ-032 When a masked pending channel is unmasked in IDLE, it is taken on the next cycle.
REQ-033 Back-to-back: ERet while other channels are eligible gives IDLE for one cycle, then REQ.

Reset
REQ-034 On Reset: state IDLE, pending=0, ExtIRQ history=0, Exc=0, EStatus=0000, ExtIAck=0, Elr=0, InHandler=0, DoubleFault=0.
REQ-035 Reset overrides every other input in the same cycle, including mid-REQ and mid-HANDLER; lines already high at release are not edges.

Structure
REQ-036 Package exc_pkg holds the state enum and the EStatus cause constants (ES_NONE, ES_IRQ0, ES_INVALID, ES_IRQ_BASE=1000).
REQ-037 Sub-module irq_prio_enc, parameterised by NUM_IRQ, outputs a valid bit plus the lowest-index set bit.

Verification
REQ-038 ExtIRQ[2] rises at cycle 5, no mask -> pending[2] at 6, Exc=1 and EStatus=1010 at 7; ExcAck at 9 with Pc=0x40 -> ExtIAck=0100 at 9, Elr=0x40 and InHandler=1 from 10.
REQ-039 NotAnInstr and ExtIRQ[0] in the same cycle -> EStatus=0010; ExtIRQ[0] is served after ERet with EStatus=0001.
REQ-040 IrqMask=0001 with ExtIRQ[0] pulsed -> no Exc; clear the mask -> Exc with EStatus=0001 one cycle later.
REQ-041 ExtIRQ[1] and ExtIRQ[3] rise together -> channel 1 served first (1001); after ERet, channel 3 (1011).
REQ-042 Reset asserted during REQ -> next cycle all outputs zero, state IDLE; ExtIRQ held high from before is not retaken.
REQ-043 NotAnInstr in HANDLER -> DoubleFault=1 and Exc stays 0; ERet -> IDLE with DoubleFault still 1.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and cause encodings for the exception / interrupt controller.
// The cause helper keeps the IRQ code mapping in one place.
package exc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HANDLER = 2'd2
  } state_e;

  localparam logic [3:0] ES_NONE     = 4'b0000;
  localparam logic [3:0] ES_IRQ0     = 4'b0001;
  localparam logic [3:0] ES_INVALID  = 4'b0010;
  localparam logic [3:0] ES_IRQ_BASE = 4'b1000;

  // Channel 0 has its own code because 1000 would collide with the base pattern.
  function automatic logic [3:0] irq_cause(input logic [2:0] ch);
    if (ch == 3'd0) begin
      return ES_IRQ0;
    end
    return ES_IRQ_BASE | {1'b0, ch};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the
// index of the lowest-numbered one.
module irq_prio_enc #(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [2:0]         idx
);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    valid = |req;
    idx   = 3'd0;
    // Scan downward so the last hit written is the lowest index.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/exc_irq_ctrl.sv
// Exception / external interrupt controller: latches IRQ edges, arbitrates
// against invalid-opcode traps and hands one non-nesting exception to the pipeline.
module exc_irq_ctrl
  import exc_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int PC_W    = 64
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [NUM_IRQ-1:0] ExtIRQ,
  input  logic [NUM_IRQ-1:0] IrqMask,
  input  logic               NotAnInstr,
  input  logic               ERet,
  input  logic               ExcAck,
  input  logic [PC_W-1:0]    Pc,
  output logic               Exc,
  output logic [3:0]         EStatus,
  output logic [NUM_IRQ-1:0] ExtIAck,
  output logic [PC_W-1:0]    Elr,
  output logic               InHandler,
  output logic               DoubleFault
);

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] irq_hist_q;
  logic               armed_q;
  logic [3:0]         estatus_q, estatus_d;
  logic [2:0]         ch_q, ch_d;
  logic [PC_W-1:0]    elr_q, elr_d;
  logic               dfault_q, dfault_d;

  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] ack_vec;
  logic               ack_fire;
  logic               win_valid;
  logic [2:0]         win_idx;

  // Edge detection is disarmed for the first cycle after reset so lines
  // already high at release load the history instead of counting as edges.
  assign irq_rise = ExtIRQ & ~irq_hist_q & {NUM_IRQ{armed_q}};
  assign eligible = pending_q & ~IrqMask;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  assign ack_fire = (state_q == ST_REQ) && ExcAck && !Reset;
  assign ack_vec  = (ack_fire && (estatus_q != ES_INVALID))
                    ? (NUM_IRQ'(1) << ch_q) : '0;

  // Clearing the acknowledged channel first lets a fresh edge re-set it.
  assign pending_d = (pending_q & ~ack_vec) | irq_rise;

  always_comb begin
    state_d   = state_q;
    estatus_d = estatus_q;
    ch_d      = ch_q;
    elr_d     = elr_q;
    dfault_d  = dfault_q;

    unique case (state_q)
      ST_IDLE: begin
        if (NotAnInstr) begin
          state_d   = ST_REQ;
          estatus_d = ES_INVALID;
        end else if (win_valid) begin
          state_d   = ST_REQ;
          estatus_d = irq_cause(win_idx);
          ch_d      = win_idx;
        end
      end
      ST_REQ: begin
        if (ExcAck) begin
          state_d = ST_HANDLER;
          elr_d   = Pc;
        end
      end
      ST_HANDLER: begin
        if (NotAnInstr) begin
          dfault_d = 1'b1;
        end
        if (ERet) begin
          state_d   = ST_IDLE;
          estatus_d = ES_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      irq_hist_q <= '0;
      armed_q    <= 1'b0;
      estatus_q  <= ES_NONE;
      ch_q       <= 3'd0;
      elr_q      <= '0;
      dfault_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      irq_hist_q <= ExtIRQ;
      armed_q    <= 1'b1;
      estatus_q  <= estatus_d;
      ch_q       <= ch_d;
      elr_q      <= elr_d;
      dfault_q   <= dfault_d;
    end
  end

  assign Exc         = (state_q == ST_REQ);
  assign InHandler   = (state_q == ST_HANDLER);
  assign EStatus     = estatus_q;
  assign ExtIAck     = ack_vec;
  assign Elr         = elr_q;
  assign DoubleFault = dfault_q;

endmodule
